// File: rtl/div_defs.sv
// Shared definitions for the divider issue controller: controller and divider
// state encodings, default parameters and result field positions.
package div_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DONE  = 2'b10,
    ST_ABORT = 2'b11
  } ctrl_state_e;

  // Internal states of the iterative divider this controller drives.
  typedef enum logic [1:0] {
    DIV_FREE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

  localparam int DATA_W_DEF       = 32;
  localparam int ABORT_CYCLES_DEF = 2;

  localparam int RES_HI_MSB = 63;
  localparam int RES_HI_LSB = 32;
  localparam int RES_LO_MSB = 31;
  localparam int RES_LO_LSB = 0;

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage issue controller for the iterative divider: start/annul handshake,
// pipeline stall, HI/LO commit. Optional DIV_ZERO_BYPASS_EN skips the divider for x/0.
module div_issue_ctrl
  import div_defs::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int ABORT_CYCLES = ABORT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_div_valid_i,
  input  logic                ex_div_signed_i,
  input  logic [DATA_W-1:0]   ex_op1_i,
  input  logic [DATA_W-1:0]   ex_op2_i,
  input  logic                ex_advance_i,
  input  logic                flush_i,
  output logic                stall_req_o,
  output logic                div_start_o,
  output logic                div_annul_o,
  output logic                div_signed_o,
  output logic [DATA_W-1:0]   div_op1_o,
  output logic [DATA_W-1:0]   div_op2_o,
  input  logic [2*DATA_W-1:0] div_result_i,
  input  logic                div_ready_i,
  output logic                hilo_we_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                busy_o
);

  localparam int CNT_W = $clog2(ABORT_CYCLES + 1);

  ctrl_state_e       state_q;
  logic [CNT_W-1:0]  abort_cnt_q;
  logic              signed_q;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      abort_cnt_q <= '0;
      signed_q    <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ex_div_valid_i && !flush_i) begin
            op1_q    <= ex_op1_i;
            op2_q    <= ex_op2_i;
            signed_q <= ex_div_signed_i;
`ifdef DIV_ZERO_BYPASS_EN
            if (ex_op2_i == '0) begin
              hi_q    <= '0;
              lo_q    <= '0;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_BUSY;
            end
`else
            state_q <= ST_BUSY;
`endif
          end
        end
        ST_BUSY: begin
          // A flush kills the divide even if the result arrives the same cycle.
          if (flush_i) begin
            abort_cnt_q <= CNT_W'(ABORT_CYCLES - 1);
            state_q     <= ST_ABORT;
          end else if (div_ready_i) begin
            hi_q    <= div_result_i[2*DATA_W-1:DATA_W];
            lo_q    <= div_result_i[DATA_W-1:0];
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (ex_advance_i || flush_i) begin
            state_q <= ST_IDLE;
          end
        end
        ST_ABORT: begin
          if (abort_cnt_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            abort_cnt_q <= abort_cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_req_o = 1'b0;
    case (state_q)
      ST_IDLE: stall_req_o = ex_div_valid_i & ~flush_i;
      ST_BUSY: stall_req_o = 1'b1;
      default: stall_req_o = 1'b0;
    endcase
  end

  assign div_start_o  = (state_q == ST_BUSY);
  assign div_annul_o  = (state_q == ST_ABORT);
  assign busy_o       = (state_q != ST_IDLE);
  assign hilo_we_o    = (state_q == ST_DONE) & ex_advance_i & ~flush_i;
  assign div_signed_o = signed_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;

endmodule
